seq_shift_add_mult: RTL and testbench
=====================================

Name: seq_shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier.
- Computes one partial product per clock using a W-bit add with carry-out. This is the same ripple-carry add path the datapath already uses, here driven iteratively.
- Sits downstream of the operand muxes and feeds the product to the next datapath stage through a start/done handshake.

Parameters:
- W, 4, operand width in bits (W >= 2); product width is 2W.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- start  input  1  request a new multiply; sampled on rising clk.
- a  input  W  multiplicand, unsigned; captured when start is accepted.
- b  input  W  multiplier, unsigned; captured when start is accepted.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; p holds a new valid result.
- p  output  2W  product register; holds last result until the next completion.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, p=0, internal registers (multiplicand, accumulator, count) = 0. Reset asserted mid-RUN aborts the operation with no done pulse. Operation resumes only after reset deasserts and a fresh start is seen.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN. Same edge: mcand<=a, acc<={W'b0, b}, count<=0.
  - RUN: one iteration per edge; count increments. After the W-th iteration -> DONE, and p<=final acc in the same edge.
  - DONE: unconditional. start=1 -> RUN with new operands captured, as in IDLE. Otherwise -> IDLE.
- Iteration (acc = {hi[W-1:0], lo[W-1:0]}):
  - If lo[0]=1: {cout, sum} = hi + mcand (W-bit add, 1-bit carry-out). Else {cout, sum} = {1'b0, hi}.
  - acc <= {cout, sum, lo[W-1:1]}, i.e. a 2W+1-bit value shifted right by one. The carry is never lost.
- Latency: start high in cycle 0 (state IDLE) -> cycles 1..W are RUN -> cycle W+1 is DONE with done=1 and p valid. Total W+1 cycles from start to done.
- Outputs:
  - busy=1 exactly in RUN cycles.
  - done=1 exactly in DONE cycles.
  - p is registered, changes only on the RUN->DONE edge, and is stable otherwise, including through the following IDLE and RUN periods.
- start while in RUN is ignored; operands are not recaptured and there is no effect on the result.
- Back-to-back: start high during the DONE cycle begins the next operation with no idle gap. Throughput is one result per W+1 cycles.
- a and b may change freely after the accept edge; results depend only on the captured values.
- Arithmetic: p = a*b exactly for all unsigned a, b in [0, 2^W-1]; maximum (2^W-1)^2 fits in 2W bits. No overflow flag.
- count width: clog2(W)+1 bits, so W=count terminal value has no wrap-around ambiguity.

Test Plan:
- W=4, reset pulse mid-idle then release; a=15, b=15, start one cycle -> busy high cycles 1-4; done pulse in cycle 5 only; p=8'hE1 (225).
- W=4: a=9, b=6 -> p=8'h36 (54). Then a=0, b=13 -> p=0. Then a=13, b=0 -> p=0. p holds 8'h36 until the second done.
- W=4: a=7, b=3 accepted. Assert start with a=15, b=15 in cycles 2 and 3 (RUN) -> ignored; done in cycle 5 with p=8'h15 (21); no extra operation follows.
- W=4: assert reset asynchronously (between clk edges) in cycle 2 of a run -> busy, done, p drop to 0 immediately. No done afterwards. A new start after release gives the correct product (a=5, b=5 -> 8'h19).
- W=4, back-to-back: start held in cycle 0 (a=3, b=4) and again in the DONE cycle 5 (a=10, b=11) -> done in cycle 5 with p=8'h0C; done in cycle 10 with p=8'h6E (110); busy low only for cycles 0, 5, 10.
- W=8: a=255, b=255 -> done in cycle 9, p=16'hFE01 (65025). Then a randomized sweep of 1000 pairs checked against a*b, asserting done width is 1 and busy never overlaps done.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier.
// One partial product per clock through a W-bit ripple-carry adder. The
// result appears W+1 cycles after start is accepted and is announced with a
// one-cycle done pulse. The adder's carry-out is shifted back into the
// accumulator, so no bit of the running sum is lost.

// One-bit full adder cell.
module seq_shift_add_mult_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// W-bit ripple-carry adder with carry-out and no carry-in.
module seq_shift_add_mult_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        seq_shift_add_mult_fa u_fa (
            .a_i (x_i[i]),
            .b_i (y_i[i]),
            .c_i (c[i]),
            .s_o (s_o[i]),
            .c_o (c[i+1])
        );
    end

    assign c_o = c[W];
endmodule

module seq_shift_add_mult #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    // One extra bit so the terminal value W is representable without wrap.
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  count_q;
    logic           busy_q;
    logic           done_q;
    logic [2*W-1:0] p_q;

    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic           cout;
    logic [2*W-1:0] acc_d;
    logic           last_iter;

    // Add the multiplicand into the high half only when the current
    // multiplier bit (acc LSB) is set; otherwise pass hi through unchanged.
    assign addend = acc_q[0] ? mcand_q : '0;

    seq_shift_add_mult_rca #(.W(W)) u_add (
        .x_i (acc_q[2*W-1:W]),
        .y_i (addend),
        .s_o (sum),
        .c_o (cout)
    );

    // {cout, sum, lo} shifted right by one: carry lands in the MSB and the
    // consumed multiplier bit falls off the bottom.
    assign acc_d     = {cout, sum, acc_q[W-1:1]};
    assign last_iter = (count_q == CW'(W - 1));

    // Control FSM with registered busy/done/p; reset aborts any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        mcand_q <= a;
                        acc_q   <= {{W{1'b0}}, b};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here.
                    acc_q   <= acc_d;
                    count_q <= count_q + CW'(1);
                    if (last_iter) begin
                        state_q <= DONE;
                        p_q     <= acc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: a W=4 and a W=8 instance share clock/reset.
// Expected products are queued at issue; a negedge monitor pops on done.
module tb_seq_shift_add_mult;
    logic        clk;
    logic        rst;
    logic        start4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];
    logic [7:0]  last_p4 = '0;
    logic [15:0] last_p8 = '0;
    logic        pd4 = 1'b0;
    logic        pd8 = 1'b0;

    seq_shift_add_mult #(.W(4)) dut4 (
        .clk(clk), .reset(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_shift_add_mult #(.W(8)) dut8 (
        .clk(clk), .reset(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected product on every done pulse.
    always @(negedge clk) begin
        if (done4) begin
            chk("done4_width", {31'b0, pd4}, 0);
            chk("done4_busy_overlap", {31'b0, busy4}, 0);
            chk("q4_has_entry", {31'b0, q4.size() != 0}, 1);
            if (q4.size() != 0) chk("p4", {24'b0, p4}, {24'b0, q4.pop_front()});
        end
        if (done8) begin
            chk("done8_width", {31'b0, pd8}, 0);
            chk("done8_busy_overlap", {31'b0, busy8}, 0);
            chk("q8_has_entry", {31'b0, q8.size() != 0}, 1);
            if (q8.size() != 0) chk("p8", {16'b0, p8}, {16'b0, q8.pop_front()});
        end
        pd4 = done4;
        pd8 = done8;
    end

    // One full operation on the W-wide instance; checks busy/done timing
    // each cycle and that p holds the previous result while running.
    // ign: pulse start with 15x15 in RUN cycles 2-3 (must be ignored).
    task automatic op(input int w, input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] e, input bit ign);
        int n = w + 1;
        @(posedge clk); #1;
        if (w == 4) begin start4 = 1; a4 = av[3:0]; b4 = bv[3:0]; q4.push_back(e[7:0]); end
        else        begin start8 = 1; a8 = av;      b8 = bv;      q8.push_back(e); end
        @(negedge clk);
        chk("busy_cycle0", {31'b0, (w == 4) ? busy4 : busy8}, 0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start4 = 0; start8 = 0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (ign && (c == 2 || c == 3)) begin start4 = 1; a4 = 4'hF; b4 = 4'hF; end
            if (ign && c == 4) start4 = 0;
            @(negedge clk);
            chk("busy", {31'b0, (w == 4) ? busy4 : busy8}, {31'b0, c < n});
            chk("done", {31'b0, (w == 4) ? done4 : done8}, {31'b0, c == n});
            if (c < n) begin
                if (w == 4) chk("p4_hold", {24'b0, p4}, {24'b0, last_p4});
                else        chk("p8_hold", {16'b0, p8}, {16'b0, last_p8});
            end
        end
        if (w == 4) last_p4 = e[7:0]; else last_p8 = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x, y;
        rst = 0; start4 = 0; start8 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;
        #1 rst = 1;
        #1;
        chk("rst_busy4", {31'b0, busy4}, 0);
        chk("rst_done4", {31'b0, done4}, 0);
        chk("rst_p4", {24'b0, p4}, 0);
        chk("rst_p8", {16'b0, p8}, 0);
        chk("rst_busy8", {31'b0, busy8}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;

        // Reset pulse while idle, then 15*15.
        @(posedge clk); #2 rst = 1; #1 rst = 0;
        op(4, 8'd15, 8'd15, 16'h00E1, 0);

        // p holds across later operations until each completion.
        op(4, 8'd9, 8'd6, 16'h0036, 0);
        op(4, 8'd0, 8'd13, 16'h0000, 0);
        op(4, 8'd13, 8'd0, 16'h0000, 0);

        // start during RUN is ignored; nothing follows the result.
        op(4, 8'd7, 8'd3, 16'h0015, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_extra_busy4", {31'b0, busy4}, 0);
            chk("no_extra_done4", {31'b0, done4}, 0);
        end

        // Asynchronous reset between edges in RUN cycle 2 aborts the op.
        @(posedge clk); #1 start4 = 1; a4 = 4'd9; b4 = 4'd9;
        @(posedge clk); #1 start4 = 0;
        @(posedge clk); #1;
        #2 rst = 1;
        #1;
        chk("arst_busy4", {31'b0, busy4}, 0);
        chk("arst_done4", {31'b0, done4}, 0);
        chk("arst_p4", {24'b0, p4}, 0);
        @(posedge clk); #1 rst = 0;
        last_p4 = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("post_rst_done4", {31'b0, done4}, 0);
            chk("post_rst_busy4", {31'b0, busy4}, 0);
        end
        op(4, 8'd5, 8'd5, 16'h0019, 0);

        // Back-to-back: second start in the DONE cycle, no idle gap.
        @(posedge clk); #1 start4 = 1; a4 = 4'd3; b4 = 4'd4; q4.push_back(8'h0C);
        @(negedge clk);
        chk("b2b_busy_c0", {31'b0, busy4}, 0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin start4 = 0; a4 = 4'hF; b4 = 4'hF; end
            if (c == 5) begin start4 = 1; a4 = 4'd10; b4 = 4'd11; q4.push_back(8'h6E); end
            if (c == 6) begin start4 = 0; a4 = 4'h0; b4 = 4'h0; end
            @(negedge clk);
            chk("b2b_busy", {31'b0, busy4}, {31'b0, !(c == 5 || c == 10)});
            chk("b2b_done", {31'b0, done4}, {31'b0, (c == 5 || c == 10)});
        end
        last_p4 = 8'h6E;

        // W=8: extreme operands then a random sweep.
        op(8, 8'd255, 8'd255, 16'hFE01, 0);
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            op(8, x, y, 16'(x) * 16'(y), 0);
        end

        repeat (3) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
